// File: rtl/stmt_lowerer_seq_scanner.sv
// Sequential bit-scan engine: grants one set, unmasked request bit per
// handshake, lowest-first or highest-first, with quartile classification.
module stmt_lowerer_seq_scanner #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_vec,
    input  logic [WIDTH-1:0]         in_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] out_idx,
    output logic [1:0]               out_class,
    output logic                     out_last,
    output logic [WIDTH-1:0]         done_vec,
    output logic                     empty
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int Q1 = WIDTH / 4;
    localparam int Q2 = WIDTH / 2;
    localparam int Q3 = 3 * WIDTH / 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic [WIDTH-1:0]   done_q, done_d;
    logic               empty_q, empty_d;
    logic [WIDTH-1:0]   accept_vec;
    logic [IDX_W-1:0]   scan_idx;
    int                 idx_int;

    // Bit position visited at step i of the scan order.
    function automatic int scan_pos(input int i);
        return (MSB_FIRST != 0) ? (WIDTH - 1 - i) : i;
    endfunction

    always_comb begin
        scan_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pend_q[scan_pos(i)]) begin
                scan_idx = IDX_W'(scan_pos(i));
                break;
            end
        end
    end

    assign out_valid = (state_q == SCAN);
    assign in_ready  = (state_q == IDLE);
    assign out_idx   = out_valid ? scan_idx : '0;
    assign out_last  = out_valid && ($countones(pend_q) == 1);
    assign done_vec  = done_q;
    assign empty     = empty_q;
    assign idx_int   = int'(scan_idx);

    always_comb begin
        out_class = 2'd0;
        if (out_valid) begin
            case (idx_int) inside
                [0:Q1-1]:  out_class = 2'd0;
                [Q1:Q2-1]: out_class = 2'd1;
                [Q2:Q3-1]: out_class = 2'd2;
                default:   out_class = 2'd3;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        done_d     = done_q;
        empty_d    = 1'b0;
        accept_vec = '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (in_mask[i]) continue;
                        accept_vec[i] = in_vec[i];
                    end
                    pend_d = accept_vec;
                    done_d = '0;
                    if (accept_vec == '0) empty_d = 1'b1;
                    else                  state_d = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pend_d[scan_idx] = 1'b0;
                    done_d[scan_idx] = 1'b1;
                    if (out_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            done_q  <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            empty_q <= empty_d;
        end
    end

endmodule

// File: tb/tb_stmt_lowerer_seq_scanner.sv
// Directed bench for stmt_lowerer_seq_scanner: LSB-first and MSB-first
// instances, inputs driven and outputs sampled on the falling edge.
module tb_stmt_lowerer_seq_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_vec = '0, in_mask = '0;
    logic       in_ready, out_valid, out_last, empty;
    logic [2:0] out_idx;
    logic [1:0] out_class;
    logic [7:0] done_vec;

    logic       m_in_valid = 1'b0, m_out_ready = 1'b0;
    logic [7:0] m_in_vec = '0, m_in_mask = '0;
    logic       m_in_ready, m_out_valid, m_out_last, m_empty;
    logic [2:0] m_out_idx;
    logic [1:0] m_out_class;
    logic [7:0] m_done_vec;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    stmt_lowerer_seq_scanner #(.WIDTH(8), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_class(out_class), .out_last(out_last),
        .done_vec(done_vec), .empty(empty)
    );

    stmt_lowerer_seq_scanner #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_vec(m_in_vec), .in_mask(m_in_mask),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_idx(m_out_idx), .out_class(m_out_class), .out_last(m_out_last),
        .done_vec(m_done_vec), .empty(m_empty)
    );

    // Bundle layout: {in_ready, out_valid, out_idx[2:0], out_class[1:0], out_last}
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if ({in_ready, out_valid, out_idx, out_class, out_last} !== 8'b1000_0000) begin
            nerr++;
            $display("FAIL reset_out: got %b want %b",
                     {in_ready, out_valid, out_idx, out_class, out_last}, 8'b1000_0000);
        end
        nvec++;
        if ({done_vec, empty} !== 9'h000) begin
            nerr++;
            $display("FAIL reset_state: got %h want 000", {done_vec, empty});
        end
        nvec++;
        if ({m_in_ready, m_out_valid, m_done_vec, m_empty} !== 11'b10_0000_0000_0) begin
            nerr++;
            $display("FAIL reset_msb: got %b want 10000000000",
                     {m_in_ready, m_out_valid, m_done_vec, m_empty});
        end
        rst = 1'b0;
    endtask

    // Accept a vector with out_ready high, then walk the expected grant list.
    task automatic run_stream(input string name, input logic [7:0] v,
                              input logic [7:0] m, input int n,
                              input logic [2:0] idxs [8],
                              input logic [1:0] cls [8],
                              input logic [7:0] final_done);
        logic [7:0] exp_done;
        in_vec = v; in_mask = m; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        exp_done = '0;
        for (int k = 0; k < n; k++) begin
            nvec++;
            if ({in_ready, out_valid, out_idx, out_class, out_last} !==
                {1'b0, 1'b1, idxs[k], cls[k], (k == n - 1)}) begin
                nerr++;
                $display("FAIL %s_grant%0d: got %b want %b", name, k,
                         {in_ready, out_valid, out_idx, out_class, out_last},
                         {1'b0, 1'b1, idxs[k], cls[k], (k == n - 1)});
            end
            nvec++;
            if (done_vec !== exp_done) begin
                nerr++;
                $display("FAIL %s_done%0d: got %h want %h", name, k, done_vec, exp_done);
            end
            exp_done[idxs[k]] = 1'b1;
            @(negedge clk);
        end
        nvec++;
        if ({in_ready, out_valid, out_idx, out_class, out_last} !== 8'b1000_0000) begin
            nerr++;
            $display("FAIL %s_idle: got %b want 10000000", name,
                     {in_ready, out_valid, out_idx, out_class, out_last});
        end
        nvec++;
        if (done_vec !== final_done) begin
            nerr++;
            $display("FAIL %s_final_done: got %h want %h", name, done_vec, final_done);
        end
    endtask

    task automatic test_basic();
        logic [2:0] idxs [8];
        logic [1:0] cls [8];
        idxs = '{3'd2, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        cls  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        run_stream("basic", 8'hA4, 8'h00, 3, idxs, cls, 8'hA4);
    endtask

    task automatic test_masked();
        logic [2:0] idxs [8];
        logic [1:0] cls [8];
        idxs = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
        cls  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        run_stream("masked", 8'hFF, 8'h55, 4, idxs, cls, 8'hAA);
    endtask

    task automatic test_all_ones();
        logic [2:0] idxs [8];
        logic [1:0] cls [8];
        idxs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        cls  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        run_stream("allones", 8'hFF, 8'h00, 8, idxs, cls, 8'hFF);
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_idx [3];
        in_vec = 8'hA4; in_mask = 8'h00; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nvec++;
            if ({in_ready, out_valid, out_idx, out_last} !== {1'b0, 1'b1, 3'd2, 1'b0}) begin
                nerr++;
                $display("FAIL stall%0d: got %b want 010100", k,
                         {in_ready, out_valid, out_idx, out_last});
            end
            // Offer an unrelated vector while busy; it must be ignored.
            in_valid = (k != 2);
            in_vec = 8'hFF;
            if (k == 2) out_ready = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        exp_idx = '{3'd2, 3'd5, 3'd7};
        for (int k = 1; k < 3; k++) begin
            nvec++;
            if ({out_valid, out_idx, out_last} !== {1'b1, exp_idx[k], (k == 2)}) begin
                nerr++;
                $display("FAIL stall_resume%0d: got %b want %b", k,
                         {out_valid, out_idx, out_last}, {1'b1, exp_idx[k], (k == 2)});
            end
            @(negedge clk);
        end
        nvec++;
        if ({in_ready, out_valid, done_vec} !== {2'b10, 8'hA4}) begin
            nerr++;
            $display("FAIL stall_end: got %h want 2a4", {in_ready, out_valid, done_vec});
        end
    endtask

    task automatic test_empty();
        in_vec = 8'h0F; in_mask = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        nvec++;
        if ({empty, out_valid, in_ready, done_vec} !== {3'b101, 8'h00}) begin
            nerr++;
            $display("FAIL empty_pulse: got %b want 10100000000",
                     {empty, out_valid, in_ready, done_vec});
        end
        @(negedge clk);
        nvec++;
        if ({empty, out_valid, in_ready} !== 3'b001) begin
            nerr++;
            $display("FAIL empty_clear: got %b want 001", {empty, out_valid, in_ready});
        end
    endtask

    task automatic test_msb_reset();
        m_in_vec = 8'hA4; m_in_mask = 8'h00; m_in_valid = 1'b1; m_out_ready = 1'b1;
        @(negedge clk);
        m_in_valid = 1'b0;
        nvec++;
        if ({m_out_valid, m_out_idx, m_out_class, m_out_last} !== {1'b1, 3'd7, 2'd3, 1'b0}) begin
            nerr++;
            $display("FAIL msb_first: got %b want 1111110",
                     {m_out_valid, m_out_idx, m_out_class, m_out_last});
        end
        @(negedge clk);
        nvec++;
        if ({m_out_valid, m_out_idx, m_out_class, m_done_vec} !== {1'b1, 3'd5, 2'd2, 8'h80}) begin
            nerr++;
            $display("FAIL msb_second: got %h want %h",
                     {m_out_valid, m_out_idx, m_out_class, m_done_vec},
                     {1'b1, 3'd5, 2'd2, 8'h80});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nvec++;
        if ({m_out_valid, m_in_ready, m_out_idx, m_done_vec} !== {2'b01, 3'd0, 8'h00}) begin
            nerr++;
            $display("FAIL msb_reset: got %b want 0100000000000",
                     {m_out_valid, m_in_ready, m_out_idx, m_done_vec});
        end
        @(negedge clk);
        nvec++;
        if ({m_out_valid, m_in_ready} !== 2'b01) begin
            nerr++;
            $display("FAIL msb_no_resume: got %b want 01", {m_out_valid, m_in_ready});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_masked();
        test_empty();
        test_all_ones();
        test_msb_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
